// File: rtl/sreg_tx.sv
// sreg_tx: LSB-first parallel-to-serial transmitter.
// Load captures a word; en advances one bit per edge; done marks word end.
module sreg_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic             sdo,
    output logic             sen,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (load) begin
                        sr    <= din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        sr <= {1'b0, sr[WIDTH-1:1]};
                        // wrap to 0 so the counter never reaches WIDTH
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign sdo  = busy & sr[0];
    assign sen  = busy & en;

endmodule

// File: tb/tb_sreg_tx.sv
// tb_sreg_tx: randomized self-checking bench for sreg_tx.
// Reference model holds the word as a queue of pending bits.
module tb_sreg_tx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       load;
    logic [7:0] din;
    logic       en;
    logic       sdo, sen, busy, done;

    logic       rx_clr;
    logic [7:0] rx;

    int vecs  = 0;
    int fails = 0;

    // model: 0 idle, 1 shifting, 2 done
    int ms;
    bit mq[$];

    sreg_tx #(.WIDTH(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .load (load),
        .din  (din),
        .en   (en),
        .sdo  (sdo),
        .sen  (sen),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_clr) rx <= 8'h00;
        else if (sen) rx <= {sdo, rx[7:1]};
    end

    function automatic logic [3:0] mo();
        if (ms == 1) return {logic'(mq[0]), en, 1'b1, 1'b0};
        if (ms == 2) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic void model_step(logic l, logic [7:0] d,
                                       logic e, logic r);
        if (!r) begin
            ms = 0;
            mq.delete();
        end else if (ms == 1) begin
            if (e) begin
                void'(mq.pop_front());
                if (mq.size() == 0) ms = 2;
            end
        end else if (l) begin
            mq.delete();
            for (int i = 0; i < 8; i++) mq.push_back(d[i]);
            ms = 1;
        end else begin
            ms = 0;
        end
    endfunction

    task automatic drive(input logic l, input logic [7:0] d,
                         input logic e);
        load = l;
        din  = d;
        en   = e;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(load, din, en, rstn);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; load = 1'b0; en = 1'b1; din = 8'hFF;
        rx_clr = 1'b1;
        model_step(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        vecs++;
        if ({sdo, sen, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_t0: got %b want 0000",
                     {sdo, sen, busy, done});
        end
        load = 1'b1;
        @(negedge clk);
        vecs++;
        if ({sdo, sen, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_held: got %b want 0000",
                     {sdo, sen, busy, done});
        end
        load = 1'b0;
        rstn = 1'b1;
        rx_clr = 1'b0;
    endtask

    task automatic test_a5();
        logic [7:0] seq;
        seq = 8'b1010_0101;
        drive(1'b1, 8'hA5, 1'b1);
        vecs++;
        if ({sdo, sen, busy, done} !== mo()) begin
            fails++;
            $display("FAIL a5_load: got %b want %b",
                     {sdo, sen, busy, done}, mo());
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            vecs++;
            if ({sdo, sen, busy, done} !== {seq[i], 3'b110}
                || mo() !== {seq[i], 3'b110}) begin
                fails++;
                $display("FAIL a5_bit%0d: got %b want %b", i,
                         {sdo, sen, busy, done}, {seq[i], 3'b110});
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b1);
        vecs++;
        if ({sdo, sen, busy, done} !== 4'b0001) begin
            fails++;
            $display("FAIL a5_done: got %b want 0001",
                     {sdo, sen, busy, done});
        end
        tick();
        vecs++;
        if ({sdo, sen, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL a5_idle: got %b want 0000",
                     {sdo, sen, busy, done});
        end
    endtask

    task automatic test_loopback();
        logic [7:0] words [5];
        words = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'($urandom)};
        foreach (words[w]) begin
            rx_clr = 1'b1;
            drive(1'b1, words[w], 1'b0);
            tick();
            rx_clr = 1'b0;
            for (int c = 0; c < 20 && ms == 1; c++) begin
                drive(1'b0, 8'($urandom), 1'b1);
                vecs++;
                if ({sdo, sen, busy, done} !== mo()) begin
                    fails++;
                    $display("FAIL loop_cyc w%0d c%0d: got %b want %b",
                             w, c, {sdo, sen, busy, done}, mo());
                end
                tick();
            end
            drive(1'b0, 8'h00, 1'b0);
            vecs++;
            if (done !== 1'b1 || rx !== words[w]) begin
                fails++;
                $display("FAIL loop_rx w%0d: got rx=%h done=%b want %h 1",
                         w, rx, done, words[w]);
            end
            tick();
        end
    endtask

    task automatic test_en_random(input logic [7:0] word, input string nm);
        int         nsen;
        logic [7:0] got;
        logic       e;
        nsen = 0;
        got  = 8'h00;
        drive(1'b1, word, 1'b0);
        tick();
        for (int c = 0; c < 200 && ms == 1; c++) begin
            e = logic'($urandom_range(0, 2) == 0);
            drive(1'b0, 8'($urandom), e);
            vecs++;
            if ({sdo, sen, busy, done} !== mo()) begin
                fails++;
                $display("FAIL %s_cyc%0d: got %b want %b", nm, c,
                         {sdo, sen, busy, done}, mo());
            end
            if (sen) begin
                got = {sdo, got[7:1]};
                nsen++;
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        vecs++;
        if (nsen !== 8 || got !== word || done !== 1'b1) begin
            fails++;
            $display("FAIL %s_word: got %0d strobes %h done=%b want 8 %h 1",
                     nm, nsen, got, done, word);
        end
        tick();
    endtask

    task automatic test_load_ignored();
        logic [7:0] got;
        got = 8'h00;
        drive(1'b1, 8'h0F, 1'b1);
        tick();
        for (int c = 0; c < 20 && ms == 1; c++) begin
            if (c == 2) drive(1'b1, 8'hFF, 1'b1);
            else drive(1'b0, 8'h00, 1'b1);
            vecs++;
            if ({sdo, sen, busy, done} !== mo()) begin
                fails++;
                $display("FAIL ign_cyc%0d: got %b want %b", c,
                         {sdo, sen, busy, done}, mo());
            end
            if (sen) got = {sdo, got[7:1]};
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        vecs++;
        if (got !== 8'h0F || done !== 1'b1) begin
            fails++;
            $display("FAIL ign_word: got %h done=%b want 0f 1", got, done);
        end
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'hA5, 1'b1);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1);
        vecs++;
        if ({sdo, sen, busy, done} !== mo()) begin
            fails++;
            $display("FAIL arst_pre: got %b want %b",
                     {sdo, sen, busy, done}, mo());
        end
        #1 rstn = 1'b0;
        #1;
        vecs++;
        if ({sdo, sen, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL arst_now: got %b want 0000",
                     {sdo, sen, busy, done});
        end
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 8'h00, 1'b1);
            vecs++;
            if ({sdo, sen, busy, done} !== 4'b0000) begin
                fails++;
                $display("FAIL arst_nodone%0d: got %b want 0000", c,
                         {sdo, sen, busy, done});
            end
            tick();
        end
        test_en_random(8'h5A, "arst_5a");
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, want;
        int          dn, odn, nb;
        want = {8'h7E, 8'h81};
        got  = 16'h0;
        dn   = 0;
        odn  = 0;
        nb   = 0;
        for (int c = 0; c < 40; c++) begin
            if (ms == 2) dn++;
            drive(logic'(dn < 2), (c == 0) ? 8'h81 : 8'h7E, 1'b1);
            vecs++;
            if ({sdo, sen, busy, done} !== mo()) begin
                fails++;
                $display("FAIL b2b_cyc%0d: got %b want %b", c,
                         {sdo, sen, busy, done}, mo());
            end
            if (done) odn++;
            if (sen) begin
                got = {sdo, got[15:1]};
                nb++;
            end
            tick();
            if (dn == 2 && ms == 0) break;
        end
        vecs++;
        if (got !== want || nb !== 16 || odn !== 2) begin
            fails++;
            $display("FAIL b2b_stream: got %h n=%0d dones=%0d want %h 16 2",
                     got, nb, odn, want);
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_loopback();
        test_en_random(8'h3C, "en_3c");
        test_load_ignored();
        test_async_reset();
        test_back_to_back();
        for (int k = 0; k < 6; k++) test_en_random(8'($urandom), "rand");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/sreg_tx.md
SREG_TX -- requirements
Module: sreg_tx

Interface
REQ-001 Parameter WIDTH, default 8, meaning number of bits per serialized word; legal range 2..32.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rstn  input  1  asynchronous, active-low reset.
REQ-004 Port load  input  1  request to capture din and start serialization.
REQ-005 Port din  input  WIDTH  parallel word to transmit.
REQ-006 Port en  input  1  shift enable; one bit advances per clk edge with en=1 while shifting.
REQ-007 Port sdo  output  1  serial data out, LSB first.
REQ-008 Port sen  output  1  serial strobe; high when sdo holds a valid bit being consumed this cycle.
REQ-009 Port busy  output  1  high while a word is being shifted out.
REQ-010 Port done  output  1  one-cycle pulse after the last bit of a word is consumed.
REQ-011 The block SHALL use one clock, clk, and an asynchronous active-low reset, rstn.

Function
REQ-012 The block SHALL implement three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE or DONE, on a clk edge with load=1, the block SHALL capture din into a WIDTH-bit shift register, clear the bit counter to 0, and enter SHIFT.
REQ-014 In IDLE with load=0, the block SHALL remain in IDLE.
REQ-015 In DONE with load=0, the block SHALL enter IDLE on the next edge.
REQ-016 In SHIFT, sdo SHALL equal shift register bit 0 combinationally; outside SHIFT, sdo SHALL be 0.
REQ-017 sen SHALL equal en AND (state==SHIFT), combinationally.
REQ-018 In SHIFT, on an edge with en=1, the shift register SHALL shift right by one with 0 entering the MSB, and the counter SHALL increment.
REQ-019 In SHIFT, on an edge with en=0, the shift register, counter and state SHALL hold.
REQ-020 In SHIFT, on an edge with en=1 and counter==WIDTH-1, the block SHALL enter DONE.
REQ-021 busy SHALL be registered-state-derived: 1 exactly when state==SHIFT.
REQ-022 done SHALL be 1 exactly when state==DONE, giving a one-cycle pulse unless load restarts SHIFT, which still leaves done high for that single DONE cycle.
REQ-023 load asserted in SHIFT SHALL be ignored with no effect on din capture, counter or state.
REQ-024 Latency: the first bit SHALL appear on sdo in the cycle after the load edge; the final bit SHALL be consumed on the WIDTH-th en=1 edge after entering SHIFT.
REQ-025 Bit order SHALL be din[0] first through din[WIDTH-1] last, so a right-shifting receiver inserting at its MSB with en driven by sen reconstructs din after WIDTH strobes.
REQ-026 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.
REQ-027 Back-to-back words SHALL be supported: load in DONE starts the next word with no IDLE cycle.

Reset
REQ-028 With rstn=0, the block SHALL immediately, without a clock edge, force state=IDLE, shift register=0, counter=0, and thus sdo=0, sen=0, busy=0, done=0.
REQ-029 Reset asserted mid-SHIFT SHALL abandon the word, and no done pulse SHALL follow.
REQ-030 After rstn deasserts, the first accepted load SHALL behave identically to a load after power-up.

Verification
REQ-031 WIDTH=8, load din=8'hA5, en=1 held: sdo sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles with sen=1 and busy=1; done=1 for 1 cycle, then IDLE.
REQ-032 Loopback: sdo/sen drive a right-shifting MSB-insert receiver (receiver reset released); after done, receiver word = 8'hA5; repeat with 8'h00, 8'hFF, 8'h01.
REQ-033 din=8'h3C, en toggled 1,0,0,1,... randomly: sdo and counter hold during en=0; exactly 8 sen pulses carry 0,0,1,1,1,1,0,0; done follows the 8th.
REQ-034 load with din=8'hFF on the third SHIFT cycle of a word 8'h0F: remaining bits still from 8'h0F; no restart.
REQ-035 rstn pulsed low asynchronously (between edges) after 4 bits of 8'hA5: outputs go 0 immediately, no done; a new load 8'h5A then transmits 0,1,0,1,1,0,1,0 correctly.
REQ-036 load held high continuously with din=8'h81 then 8'h7E: done pulses once per word, second word starts in the DONE cycle, sdo stream 1,0,0,0,0,0,0,1,0,1,1,1,1,1,1,0.
